// File: rtl/nreno_timeout_engine.sv
// nreno_timeout_engine
// Two-stage NewReno retransmission-timeout handler shared by all flows.
// Stage 1 registers the request and its flight size; stage 2 registers the
// retransmit range, the new window/context and the RTO.
// Optional build macro: NRENO_TO_BACKOFF_EN (RTO exponential backoff).
module nreno_timeout_engine #(
   parameter int SEQ_W       = 32,
   parameter int WIN_W       = 9,
   parameter int TIMER_W     = 32,
   parameter int FLOW_ID_W   = 10,
   parameter int BO_W        = 3,
   parameter int MAX_BACKOFF = 6,
   parameter int RTX_BURST   = 4,
   parameter int LOSS_WND    = 1,
   parameter int CTX_W       = 4*WIN_W+SEQ_W+BO_W+2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FLOW_ID_W-1:0] in_flow_id,
   input  logic                 timeout_expired,
   input  logic [SEQ_W-1:0]     wnd_start_in,
   input  logic [SEQ_W-1:0]     next_new_in,
   input  logic [WIN_W-1:0]     wnd_size_in,
   input  logic [TIMER_W-1:0]   rtx_timer_amnt_in,
   input  logic [CTX_W-1:0]     user_cntxt_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLOW_ID_W-1:0] out_flow_id,
   output logic                 mark_rtx,
   output logic [SEQ_W-1:0]     rtx_start,
   output logic [SEQ_W-1:0]     rtx_end,
   output logic [WIN_W-1:0]     wnd_size_out,
   output logic [TIMER_W-1:0]   rtx_timer_amnt_out,
   output logic [CTX_W-1:0]     user_cntxt_out,
   output logic [31:0]          timeout_cnt
);

   // Stage 1 registers
   logic                 r_s1_valid;
   logic                 r_s1_timeout;
   logic [FLOW_ID_W-1:0] r_s1_flow_id;
   logic [SEQ_W-1:0]     r_s1_wnd_start;
   logic [SEQ_W-1:0]     r_s1_next_new;
   logic [SEQ_W-1:0]     r_s1_flight;
   logic [WIN_W-1:0]     r_s1_wnd_size;
   logic [TIMER_W-1:0]   r_s1_rto;
   logic [CTX_W-1:0]     r_s1_cntxt;

   // Stage 2 (output) registers
   logic                 r_out_valid;
   logic [FLOW_ID_W-1:0] r_out_flow_id;
   logic                 r_mark_rtx;
   logic [SEQ_W-1:0]     r_rtx_start;
   logic [SEQ_W-1:0]     r_rtx_end;
   logic [WIN_W-1:0]     r_wnd_size;
   logic [TIMER_W-1:0]   r_rto;
   logic [CTX_W-1:0]     r_cntxt;
   logic [31:0]          r_timeout_cnt;

   // Combinational timeout results computed from stage 1
   logic                 w_adv;
   logic [SEQ_W-1:0]     w_burst;
   logic [SEQ_W-1:0]     w_recover;
   logic [WIN_W-1:0]     w_flight_clamped;
   logic [WIN_W-1:0]     w_half_flight;
   logic [WIN_W-1:0]     w_ss_thresh;
   logic [BO_W-1:0]      w_backoff_in;
   logic [BO_W-1:0]      w_backoff_new;
   logic [TIMER_W-1:0]   w_rto_timeout;
   logic [CTX_W-1:0]     w_cntxt_timeout;

   // Both stages advance together; a stalled output freezes the whole pipe.
   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   assign out_valid          = r_out_valid;
   assign out_flow_id        = r_out_flow_id;
   assign mark_rtx           = r_mark_rtx;
   assign rtx_start          = r_rtx_start;
   assign rtx_end            = r_rtx_end;
   assign wnd_size_out       = r_wnd_size;
   assign rtx_timer_amnt_out = r_rto;
   assign user_cntxt_out     = r_cntxt;
   assign timeout_cnt        = r_timeout_cnt;

   // Burst size, flight-based ss_thresh, backoff and the rebuilt context
   always_comb begin
      w_backoff_in = r_s1_cntxt[CTX_W-1 -: BO_W];

      // At least one segment is always marked, even with nothing in flight.
      if (r_s1_flight == '0)
         w_burst = SEQ_W'(1);
      else if (r_s1_flight < SEQ_W'(RTX_BURST))
         w_burst = r_s1_flight;
      else
         w_burst = SEQ_W'(RTX_BURST);

      // Flight sizes beyond the window field saturate before halving.
      if (|r_s1_flight[SEQ_W-1:WIN_W])
         w_flight_clamped = '1;
      else
         w_flight_clamped = r_s1_flight[WIN_W-1:0];

      w_half_flight = w_flight_clamped >> 1;
      w_ss_thresh   = (w_half_flight < WIN_W'(2)) ? WIN_W'(2) : w_half_flight;

      if (w_backoff_in >= BO_W'(MAX_BACKOFF))
         w_backoff_new = BO_W'(MAX_BACKOFF);
      else
         w_backoff_new = w_backoff_in + BO_W'(1);

      w_recover = r_s1_next_new - SEQ_W'(1);

      w_cntxt_timeout = {w_backoff_new, 1'b0, w_recover, 1'b1,
                         {WIN_W{1'b0}}, w_ss_thresh, {WIN_W{1'b0}},
                         WIN_W'(LOSS_WND)};
   end

`ifdef NRENO_TO_BACKOFF_EN
   // Wide enough to hold the largest possible shift without losing bits.
   localparam int SH_W = TIMER_W + (2**BO_W) - 1;
   logic [SH_W-1:0] w_rto_wide;

   // RTO scaled by 2^backoff, saturating to all-ones on overflow
   always_comb begin
      w_rto_wide    = SH_W'(r_s1_rto) << w_backoff_new;
      w_rto_timeout = (|w_rto_wide[SH_W-1:TIMER_W]) ? {TIMER_W{1'b1}}
                                                    : w_rto_wide[TIMER_W-1:0];
   end
`else
   assign w_rto_timeout = r_s1_rto;
`endif

   // Stage 1: capture the request and its flight size (modular difference)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid     <= 1'b0;
         r_s1_timeout   <= 1'b0;
         r_s1_flow_id   <= '0;
         r_s1_wnd_start <= '0;
         r_s1_next_new  <= '0;
         r_s1_flight    <= '0;
         r_s1_wnd_size  <= '0;
         r_s1_rto       <= '0;
         r_s1_cntxt     <= '0;
      end else if (w_adv) begin
         r_s1_valid     <= in_valid;
         r_s1_timeout   <= timeout_expired;
         r_s1_flow_id   <= in_flow_id;
         r_s1_wnd_start <= wnd_start_in;
         r_s1_next_new  <= next_new_in;
         r_s1_flight    <= next_new_in - wnd_start_in;
         r_s1_wnd_size  <= wnd_size_in;
         r_s1_rto       <= rtx_timer_amnt_in;
         r_s1_cntxt     <= user_cntxt_in;
      end
   end

   // Stage 2: register results; data holds when no new request arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_flow_id <= '0;
         r_mark_rtx    <= 1'b0;
         r_rtx_start   <= '0;
         r_rtx_end     <= '0;
         r_wnd_size    <= '0;
         r_rto         <= '0;
         r_cntxt       <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_flow_id <= r_s1_flow_id;
            r_rtx_start   <= r_s1_wnd_start;
            if (r_s1_timeout) begin
               r_mark_rtx <= 1'b1;
               r_rtx_end  <= r_s1_wnd_start + w_burst;
               r_wnd_size <= WIN_W'(LOSS_WND);
               r_rto      <= w_rto_timeout;
               r_cntxt    <= w_cntxt_timeout;
            end else begin
               r_mark_rtx <= 1'b0;
               r_rtx_end  <= r_s1_wnd_start;
               r_wnd_size <= r_s1_wnd_size;
               r_rto      <= r_s1_rto;
               r_cntxt    <= r_s1_cntxt;
            end
         end
      end
   end

   // Saturating count of timeout results actually handed to the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeout_cnt <= '0;
      end else if (r_out_valid && out_ready && r_mark_rtx && (r_timeout_cnt != 32'hFFFF_FFFF)) begin
         r_timeout_cnt <= r_timeout_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_nreno_timeout_engine.sv
// Testbench for nreno_timeout_engine: a reference model pushes expected
// results into a scoreboard queue at request acceptance; each scenario task
// pops and compares as results are handed off.
module tb_nreno_timeout_engine;

   localparam int SEQ_W       = 32;
   localparam int WIN_W       = 9;
   localparam int TIMER_W     = 32;
   localparam int FLOW_ID_W   = 10;
   localparam int BO_W        = 3;
   localparam int MAX_BACKOFF = 6;
   localparam int RTX_BURST   = 4;
   localparam int LOSS_WND    = 1;
   localparam int CTX_W       = 4*WIN_W+SEQ_W+BO_W+2;

   typedef struct packed {
      logic [FLOW_ID_W-1:0] flow;
      logic                 to;
      logic [SEQ_W-1:0]     ws;
      logic [SEQ_W-1:0]     nn;
      logic [WIN_W-1:0]     wsz;
      logic [TIMER_W-1:0]   rto;
      logic [CTX_W-1:0]     ctx;
   } req_t;

   typedef struct packed {
      logic [FLOW_ID_W-1:0] flow;
      logic                 mark;
      logic [SEQ_W-1:0]     rs;
      logic [SEQ_W-1:0]     re;
      logic [WIN_W-1:0]     wsz;
      logic [TIMER_W-1:0]   rto;
      logic [CTX_W-1:0]     ctx;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [FLOW_ID_W-1:0] in_flow_id = '0;
   logic                 timeout_expired = 1'b0;
   logic [SEQ_W-1:0]     wnd_start_in = '0;
   logic [SEQ_W-1:0]     next_new_in = '0;
   logic [WIN_W-1:0]     wnd_size_in = '0;
   logic [TIMER_W-1:0]   rtx_timer_amnt_in = '0;
   logic [CTX_W-1:0]     user_cntxt_in = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [FLOW_ID_W-1:0] out_flow_id;
   logic                 mark_rtx;
   logic [SEQ_W-1:0]     rtx_start;
   logic [SEQ_W-1:0]     rtx_end;
   logic [WIN_W-1:0]     wnd_size_out;
   logic [TIMER_W-1:0]   rtx_timer_amnt_out;
   logic [CTX_W-1:0]     user_cntxt_out;
   logic [31:0]          timeout_cnt;

   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_to_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   nreno_timeout_engine dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_flow_id(in_flow_id),
      .timeout_expired(timeout_expired), .wnd_start_in(wnd_start_in),
      .next_new_in(next_new_in), .wnd_size_in(wnd_size_in),
      .rtx_timer_amnt_in(rtx_timer_amnt_in), .user_cntxt_in(user_cntxt_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_flow_id(out_flow_id),
      .mark_rtx(mark_rtx), .rtx_start(rtx_start), .rtx_end(rtx_end),
      .wnd_size_out(wnd_size_out), .rtx_timer_amnt_out(rtx_timer_amnt_out),
      .user_cntxt_out(user_cntxt_out), .timeout_cnt(timeout_cnt)
   );

   // Reference model of one request
   function automatic exp_t model(input req_t r);
      exp_t            e;
      longint unsigned fl, n, fc, ss, t;
      int              bo;
      logic [SEQ_W-1:0] rec;
      e.flow = r.flow;
      e.rs   = r.ws;
      if (!r.to) begin
         e.mark = 1'b0;
         e.re   = r.ws;
         e.wsz  = r.wsz;
         e.rto  = r.rto;
         e.ctx  = r.ctx;
      end else begin
         fl = ({32'd0, r.nn} + 64'h1_0000_0000 - {32'd0, r.ws}) & 64'hFFFF_FFFF;
         if (fl == 0) n = 1;
         else if (fl < RTX_BURST) n = fl;
         else n = RTX_BURST;
         fc = (fl > 511) ? 511 : fl;
         ss = fc / 2;
         if (ss < 2) ss = 2;
         bo = int'(r.ctx[CTX_W-1 -: BO_W]) + 1;
         if (bo > MAX_BACKOFF) bo = MAX_BACKOFF;
         rec    = r.nn - 32'd1;
         e.mark = 1'b1;
         e.re   = r.ws + n[31:0];
         e.wsz  = 9'(LOSS_WND);
         e.ctx  = {bo[2:0], 1'b0, rec, 1'b1, 9'd0, ss[8:0], 9'd0, 9'(LOSS_WND)};
`ifdef NRENO_TO_BACKOFF_EN
         t = {32'd0, r.rto} << bo;
         e.rto = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
`else
         t = {32'd0, r.rto};
         e.rto = t[31:0];
`endif
      end
      return e;
   endfunction

   // Drive one request and wait (bounded) for acceptance
   task automatic send(input req_t r);
      bit acc;
      acc = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_flow_id = r.flow; timeout_expired = r.to;
      wnd_start_in = r.ws; next_new_in = r.nn; wnd_size_in = r.wsz;
      rtx_timer_amnt_in = r.rto; user_cntxt_in = r.ctx;
      for (int k = 0; k < 100 && !acc; k++) begin
         #1 acc = in_ready;
         @(posedge clk);
         if (!acc) @(negedge clk);
      end
      if (acc) sb.push_back(model(r));
      else begin
         n_tests++; n_fail++;
         $display("FAIL send_accept flow=%0h in_ready stayed 0, required 1 within 100 cycles", r.flow);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic req_t rand_req(input logic [FLOW_ID_W-1:0] f, input logic to);
      req_t r;
      logic [95:0] c;
      c = {$urandom, $urandom, $urandom};
      r.flow = f; r.to = to; r.ws = $urandom;
      r.nn = r.ws + 32'($urandom_range(0, 2000));
      r.wsz = 9'($urandom); r.rto = $urandom; r.ctx = c[CTX_W-1:0];
      return r;
   endfunction

   task automatic test_reset();
      exp_t o;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2;
      o = {out_flow_id, mark_rtx, rtx_start, rtx_end, wnd_size_out, rtx_timer_amnt_out, user_cntxt_out};
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
      n_tests++;
      if (timeout_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_timeout_cnt got %0h required 0", timeout_cnt); end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
      n_tests++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_outputs got %0h required 0", o); end
      exp_to_cnt = 0;
      $display("[TB] test_reset done");
   endtask

   task automatic test_single_timeout();
      req_t r;
      exp_t e, o;
      int   got, cyc, lat;
      r = '{flow:10'h011, to:1'b1, ws:32'd100, nn:32'd110, wsz:9'd20, rto:32'd1000, ctx:'0};
      got = 0; cyc = 0; lat = 0;
      fork
         begin send(r); idle(); end
         begin
            while (got < 1 && cyc < 50) begin
               @(negedge clk); #2; cyc++;
               if (out_valid && out_ready) begin
                  o = {out_flow_id, mark_rtx, rtx_start, rtx_end, wnd_size_out, rtx_timer_amnt_out, user_cntxt_out};
                  e = (sb.size() != 0) ? sb.pop_front() : '0;
                  if (e.mark) exp_to_cnt++;
                  n_tests++;
                  if (o !== e) begin
                     n_fail++;
                     $display("FAIL single_to got flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h required flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h",
                              o.flow, o.mark, o.rs, o.re, o.wsz, o.rto, o.ctx, e.flow, e.mark, e.rs, e.re, e.wsz, e.rto, e.ctx);
                  end
                  lat = cyc;
                  got++;
               end
            end
         end
      join
      n_tests++;
      if (got != 1) begin n_fail++; $display("FAIL single_to_count got %0d results required 1", got); end
      // Request driven at negedge 1, captured at the following edge, result after the second edge.
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL single_to_latency got sample %0d required 3", lat); end
      @(negedge clk); #2;
      n_tests++;
      if (timeout_cnt !== 32'd1) begin n_fail++; $display("FAIL single_to_cnt got %0d required 1", timeout_cnt); end
      $display("[TB] test_single_timeout done rtx_end=%0d", rtx_end);
   endtask

   task automatic test_timeout_corners();
      req_t rq[$];
      req_t r;
      exp_t e, o;
      int   got, cyc, nreq;
      r = '{flow:10'h021, to:1'b1, ws:32'hFFFF_FFFF, nn:32'h0000_0001, wsz:9'd7, rto:32'd50, ctx:'0};
      rq.push_back(r);
      r = '{flow:10'h022, to:1'b1, ws:32'd5000, nn:32'd5000, wsz:9'd7, rto:32'h1000_0000, ctx:{3'd6, 70'd0}};
      rq.push_back(r);
      r = '{flow:10'h023, to:1'b1, ws:32'd0, nn:32'd100000, wsz:9'd300, rto:32'h0800_0000, ctx:{3'd4, 70'h5A5}};
      rq.push_back(r);
      r = '{flow:10'h024, to:1'b1, ws:32'd10, nn:32'd13, wsz:9'd3, rto:32'd7, ctx:{3'd7, 70'd0}};
      rq.push_back(r);
      for (int i = 0; i < 4; i++) rq.push_back(rand_req(10'(32 + 5 + i), 1'b1));
      nreq = rq.size();
      got = 0; cyc = 0;
      fork
         begin
            foreach (rq[i]) send(rq[i]);
            idle();
         end
         begin
            while (got < nreq && cyc < 200) begin
               @(negedge clk); #2; cyc++;
               if (out_valid && out_ready) begin
                  o = {out_flow_id, mark_rtx, rtx_start, rtx_end, wnd_size_out, rtx_timer_amnt_out, user_cntxt_out};
                  e = (sb.size() != 0) ? sb.pop_front() : '0;
                  if (e.mark) exp_to_cnt++;
                  n_tests++;
                  if (o !== e) begin
                     n_fail++;
                     $display("FAIL corner_to[%0d] got flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h required flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h",
                              got, o.flow, o.mark, o.rs, o.re, o.wsz, o.rto, o.ctx, e.flow, e.mark, e.rs, e.re, e.wsz, e.rto, e.ctx);
                  end
                  got++;
               end
            end
         end
      join
      n_tests++;
      if (got != nreq) begin n_fail++; $display("FAIL corner_to_count got %0d results required %0d", got, nreq); end
      @(negedge clk); #2;
      n_tests++;
      if (timeout_cnt !== 32'(exp_to_cnt)) begin n_fail++; $display("FAIL corner_to_cnt got %0d required %0d", timeout_cnt, exp_to_cnt); end
      $display("[TB] test_timeout_corners done results=%0d", got);
   endtask

   task automatic test_passthrough();
      req_t rq[$];
      exp_t e, o;
      int   got, cyc;
      for (int i = 0; i < 5; i++) rq.push_back(rand_req(10'(64 + i), 1'b0));
      got = 0; cyc = 0;
      fork
         begin
            foreach (rq[i]) send(rq[i]);
            idle();
         end
         begin
            while (got < 5 && cyc < 200) begin
               @(negedge clk); #2; cyc++;
               if (out_valid && out_ready) begin
                  o = {out_flow_id, mark_rtx, rtx_start, rtx_end, wnd_size_out, rtx_timer_amnt_out, user_cntxt_out};
                  e = (sb.size() != 0) ? sb.pop_front() : '0;
                  if (e.mark) exp_to_cnt++;
                  n_tests++;
                  if (o !== e) begin
                     n_fail++;
                     $display("FAIL passthru[%0d] got flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h required flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h",
                              got, o.flow, o.mark, o.rs, o.re, o.wsz, o.rto, o.ctx, e.flow, e.mark, e.rs, e.re, e.wsz, e.rto, e.ctx);
                  end
                  got++;
               end
            end
         end
      join
      n_tests++;
      if (got != 5) begin n_fail++; $display("FAIL passthru_count got %0d results required 5", got); end
      @(negedge clk); #2;
      n_tests++;
      if (timeout_cnt !== 32'(exp_to_cnt)) begin n_fail++; $display("FAIL passthru_cnt got %0d required %0d", timeout_cnt, exp_to_cnt); end
      $display("[TB] test_passthrough done results=%0d", got);
   endtask

   task automatic test_back_to_back();
      req_t rq[$];
      exp_t e, o, o_prev;
      int   got, cyc;
      bit   stalled_prev;
      for (int i = 0; i < 5; i++) rq.push_back(rand_req(10'(128 + i), 1'(i % 2 == 0)));
      got = 0; cyc = 0; stalled_prev = 1'b0; o_prev = '0;
      fork
         begin
            foreach (rq[i]) send(rq[i]);
            idle();
         end
         begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               out_ready = !(c >= 3 && c <= 6);
            end
            out_ready = 1'b1;
         end
         begin
            while (got < 5 && cyc < 200) begin
               @(negedge clk); #2; cyc++;
               o = {out_flow_id, mark_rtx, rtx_start, rtx_end, wnd_size_out, rtx_timer_amnt_out, user_cntxt_out};
               if (stalled_prev) begin
                  n_tests++;
                  if (out_valid !== 1'b1 || o !== o_prev) begin
                     n_fail++;
                     $display("FAIL stall_stable got valid=%0b data=%0h required valid=1 data=%0h", out_valid, o, o_prev);
                  end
               end
               if (out_valid && !out_ready) begin
                  n_tests++;
                  if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b required 0", in_ready); end
               end
               stalled_prev = out_valid && !out_ready;
               o_prev = o;
               if (out_valid && out_ready) begin
                  e = (sb.size() != 0) ? sb.pop_front() : '0;
                  if (e.mark) exp_to_cnt++;
                  n_tests++;
                  if (o !== e) begin
                     n_fail++;
                     $display("FAIL b2b[%0d] got flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h required flow=%0h mark=%0b rs=%0h re=%0h wnd=%0h rto=%0h ctx=%0h",
                              got, o.flow, o.mark, o.rs, o.re, o.wsz, o.rto, o.ctx, e.flow, e.mark, e.rs, e.re, e.wsz, e.rto, e.ctx);
                  end
                  got++;
               end
            end
         end
      join
      n_tests++;
      if (got != 5) begin n_fail++; $display("FAIL b2b_count got %0d results required 5", got); end
      repeat (3) begin
         @(negedge clk); #2;
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate got out_valid=%0b flow=%0h required 0", out_valid, out_flow_id); end
      end
      n_tests++;
      if (timeout_cnt !== 32'(exp_to_cnt)) begin n_fail++; $display("FAIL b2b_cnt got %0d required %0d", timeout_cnt, exp_to_cnt); end
      $display("[TB] test_back_to_back done results=%0d", got);
   endtask

   task automatic test_reset_midstream();
      send(rand_req(10'h1F0, 1'b1));
      send(rand_req(10'h1F1, 1'b1));
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %0b required 0", out_valid); end
      n_tests++;
      if (timeout_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d required 0", timeout_cnt); end
      rst = 1'b0;
      sb.delete();
      exp_to_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #2;
         n_tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_drained[%0d] got out_valid=%0b in_ready=%0b flow=%0h required out_valid=0 in_ready=1", i, out_valid, in_ready, out_flow_id);
         end
      end
      $display("[TB] test_reset_midstream done");
   endtask

   initial begin
      test_reset();
      test_single_timeout();
      test_timeout_corners();
      test_passthrough();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
